// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/round constants, round-constant table,
// small sigma functions and the message-schedule FSM state type.
// Consumed by the message schedule, the K ROM and the round stage.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int ROUNDS    = 64;
  localparam int IDX_W     = $clog2(ROUNDS);
  localparam int WIN_WORDS = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} sched_state_t;

  localparam word_t K_TABLE [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // sigma0: ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1: ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Block-in / round-out bus between a block source and the message schedule.
// master = the side supplying blocks (and watching the round stream),
// slave  = the message schedule itself.
interface sha256_msg_schedule_if;
  import sha256_pkg::*;

  logic             start;
  logic [511:0]     block_in;
  logic             enable;
  word_t            cur_w;
  word_t            cur_k;
  logic [IDX_W-1:0] wk_vector_index;
  logic             wk_index_complete;
  logic             busy;
  logic             done;

  modport master (
    output start, block_in,
    input  enable, cur_w, cur_k, wk_vector_index, wk_index_complete, busy, done
  );

  modport slave (
    input  start, block_in,
    output enable, cur_w, cur_k, wk_vector_index, wk_index_complete, busy, done
  );
endinterface

// File: rtl/sha256_k_rom.sv
// Combinational round-index -> K[t] lookup, shared by SHA-256 blocks.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output word_t            k
);
  assign k = K_TABLE[index];
endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: captures one 512-bit block and streams
// W[t]/K[t] for t=0..63 to the round stage, one round per cycle, using a
// 16-word sliding window.
// Optional: define SHA256_SCHED_BLOCK_CNT_EN to add a saturating
// block_count output counting completed blocks.
module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int WK_LENGTH = ROUNDS
) (
  input  logic                clock,
  input  logic                reset,
  sha256_msg_schedule_if.slave bus
`ifdef SHA256_SCHED_BLOCK_CNT_EN
  ,
  output logic [WORD_W-1:0]   block_count
`endif
);

  localparam int IW = $clog2(WK_LENGTH);

  sched_state_t state, next_state;
  logic [IW-1:0] idx;
  logic [WIN_WORDS-1:0][WORD_W-1:0] win;
  word_t w_new;
  logic  last;
  logic  enable_c, busy_c, done_c, complete_c;

  assign last  = (idx == IW'(WK_LENGTH - 1));
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    next_state = state;
    enable_c   = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    complete_c = 1'b0;
    unique case (state)
      IDLE: if (bus.start) next_state = LOAD;
      LOAD: begin
        busy_c     = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        busy_c     = 1'b1;
        enable_c   = 1'b1;
        complete_c = last;
        if (last) next_state = DONE;
      end
      DONE: begin
        enable_c   = 1'b1;
        complete_c = 1'b1;
        done_c     = 1'b1;
        if (bus.start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Window capture/shift and round index; index parks at the last round in DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      idx <= '0;
      win <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: if (bus.start) begin
          idx <= '0;
          for (int i = 0; i < WIN_WORDS; i++)
            win[i] <= bus.block_in[(WIN_WORDS-1-i)*WORD_W +: WORD_W];
        end
        LOAD: idx <= '0;
        RUN: begin
          win <= {w_new, win[WIN_WORDS-1:1]};
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SHA256_SCHED_BLOCK_CNT_EN
  // Completed-block counter, bumps on RUN->DONE and sticks at all-ones
  always_ff @(posedge clock) begin
    if (reset)
      block_count <= '0;
    else if (state == RUN && last && block_count != '1)
      block_count <= block_count + 1'b1;
  end
`endif

  sha256_k_rom u_k_rom (
    .index (idx),
    .k     (bus.cur_k)
  );

  assign bus.cur_w             = win[0];
  assign bus.wk_vector_index   = idx;
  assign bus.enable            = enable_c;
  assign bus.busy              = busy_c;
  assign bus.done              = done_c;
  assign bus.wk_index_complete = complete_c;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: reset values, the "abc" block
// schedule, handshake timing, back-to-back blocks, ignored start, mid-block
// reset and (when SHA256_SCHED_BLOCK_CNT_EN is defined) the block counter.
module tb_sha256_msg_schedule;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sha256_msg_schedule_if bus ();
`ifdef SHA256_SCHED_BLOCK_CNT_EN
  logic [31:0] block_count;
`endif

  sha256_msg_schedule dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef SHA256_SCHED_BLOCK_CNT_EN
    ,
    .block_count (block_count)
`endif
  );

  typedef struct {
    int          idx;
    logic [31:0] w;
    logic [31:0] k;
    bit          chk_w;
  } vec_t;

  vec_t tbl [10];
  int checks   = 0;
  int failures = 0;

  logic [511:0] abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
  logic [511:0] blk2    = {32'hDEADBEEF, 32'h00000001, {14{32'h0}}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_enable"},   32'(bus.enable), 32'd0);
    chk({tag, "_complete"}, 32'(bus.wk_index_complete), 32'd0);
    chk({tag, "_busy"},     32'(bus.busy), 32'd0);
    chk({tag, "_done"},     32'(bus.done), 32'd0);
    chk({tag, "_index"},    32'(bus.wk_vector_index), 32'd0);
    chk({tag, "_cur_k"},    bus.cur_k, 32'h428a2f98);
    chk({tag, "_cur_w"},    bus.cur_w, 32'h0);
  endtask

  // Drive start for one cycle; returns at the first LOAD sample point
  task automatic pulse_start(input logic [511:0] b);
    bus.block_in = b;
    bus.start    = 1'b1;
    cyc();
    bus.start    = 1'b0;
  endtask

  // Full block with a bounded wait for done; start-to-done must be 66 cycles
  task automatic run_block(input logic [511:0] b);
    int n;
    pulse_start(b);
    n = 1;
    while (!bus.done && n < 100) begin
      cyc();
      n++;
    end
    chk("done_latency", n, 66);
  endtask

  initial begin
    tbl[0] = '{0,  32'h61626380, 32'h428a2f98, 1'b1};
    tbl[1] = '{1,  32'h00000000, 32'h71374491, 1'b1};
    tbl[2] = '{14, 32'h00000000, 32'h9bdc06a7, 1'b1};
    tbl[3] = '{15, 32'h00000018, 32'hc19bf174, 1'b1};
    tbl[4] = '{16, 32'h61626380, 32'he49b69c1, 1'b1};
    tbl[5] = '{17, 32'h000F0000, 32'hefbe4786, 1'b1};
    tbl[6] = '{18, 32'h7DA86405, 32'h0fc19dc6, 1'b1};
    tbl[7] = '{19, 32'h600003C6, 32'h240ca1cc, 1'b1};
    tbl[8] = '{32, 32'h00000000, 32'h27b70a85, 1'b0};
    tbl[9] = '{63, 32'h00000000, 32'hc67178f2, 1'b0};

    bus.start    = 1'b0;
    bus.block_in = '0;

    // Reset held for two cycles
    reset = 1'b1;
    cyc();
    cyc();
    chk_reset_vals("reset");
`ifdef SHA256_SCHED_BLOCK_CNT_EN
    chk("reset_block_count", block_count, 32'd0);
`endif
    reset = 1'b0;
    cyc();
    chk("idle_enable", 32'(bus.enable), 32'd0);

    // "abc" block: LOAD cycle, then 64 rounds checked against the table
    pulse_start(abc_blk);
    chk("load_enable",   32'(bus.enable), 32'd0);
    chk("load_busy",     32'(bus.busy), 32'd1);
    chk("load_index",    32'(bus.wk_vector_index), 32'd0);
    chk("load_complete", 32'(bus.wk_index_complete), 32'd0);
    cyc();
    for (int t = 0; t < 64; t++) begin
      chk("run_index",    32'(bus.wk_vector_index), 32'(t));
      chk("run_enable",   32'(bus.enable), 32'd1);
      chk("run_complete", 32'(bus.wk_index_complete), (t == 63) ? 32'd1 : 32'd0);
      chk("run_done",     32'(bus.done), 32'd0);
      for (int v = 0; v < 10; v++) begin
        if (tbl[v].idx == t) begin
          if (tbl[v].chk_w) chk("abc_cur_w", bus.cur_w, tbl[v].w);
          chk("abc_cur_k", bus.cur_k, tbl[v].k);
        end
      end
      cyc();
    end
    // 66 cycles after the start cycle: DONE
    chk("done_flag",     32'(bus.done), 32'd1);
    chk("done_busy",     32'(bus.busy), 32'd0);
    chk("done_enable",   32'(bus.enable), 32'd1);
    chk("done_complete", 32'(bus.wk_index_complete), 32'd1);
    chk("done_index",    32'(bus.wk_vector_index), 32'd63);

    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_enable",   32'(bus.enable), 32'd1);
      chk("hold_complete", 32'(bus.wk_index_complete), 32'd1);
      chk("hold_done",     32'(bus.done), 32'd1);
      chk("hold_index",    32'(bus.wk_vector_index), 32'd63);
    end

    // Back-to-back: start from DONE, ignored start at 30, reset at 40
    pulse_start(blk2);
    chk("b2b_load_enable",   32'(bus.enable), 32'd0);
    chk("b2b_load_complete", 32'(bus.wk_index_complete), 32'd0);
    chk("b2b_load_index",    32'(bus.wk_vector_index), 32'd0);
    chk("b2b_load_done",     32'(bus.done), 32'd0);
    cyc();
    chk("b2b_index0", 32'(bus.wk_vector_index), 32'd0);
    chk("b2b_w0",     bus.cur_w, 32'hDEADBEEF);
    chk("b2b_k0",     bus.cur_k, 32'h428a2f98);
    chk("b2b_enable", 32'(bus.enable), 32'd1);
    for (int t = 1; t <= 40; t++) begin
      cyc();
      bus.start = 1'b0;
      chk("b2b_index", 32'(bus.wk_vector_index), 32'(t));
      chk("b2b_busy",  32'(bus.busy), 32'd1);
      if (t == 1)  chk("b2b_w1",  bus.cur_w, 32'h00000001);
      if (t == 16) chk("b2b_w16", bus.cur_w, 32'hE0ADFEEF);
      if (t == 17) chk("b2b_w17", bus.cur_w, 32'h00000001);
      if (t == 30) begin
        bus.block_in = abc_blk;
        bus.start    = 1'b1;
      end
      if (t == 40) reset = 1'b1;
    end
    cyc();
    chk_reset_vals("midreset");
    reset = 1'b0;
    cyc();
    chk("post_reset_busy", 32'(bus.busy), 32'd0);

    // Three consecutive blocks
    run_block(abc_blk);
    run_block(blk2);
    run_block(abc_blk);
    chk("three_done_index", 32'(bus.wk_vector_index), 32'd63);
`ifdef SHA256_SCHED_BLOCK_CNT_EN
    chk("block_count_3", block_count, 32'd3);
    reset = 1'b1;
    cyc();
    chk("block_count_reset", block_count, 32'd0);
    reset = 1'b0;
`else
    reset = 1'b1;
    cyc();
    chk("final_reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
`endif
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
